// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter in front of a single apb_master command port.
// Optional macro ARB_LOCK_EN adds i_lock to hold the rotation on a requester.
module apb_req_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ*AW-1:0] i_addr,
  input  logic [NREQ*DW-1:0] i_wdata,
  input  logic [NREQ-1:0]    i_write,
`ifdef ARB_LOCK_EN
  input  logic [NREQ-1:0]    i_lock,
`endif
  output logic [NREQ-1:0]    o_gnt,
  output logic [NREQ-1:0]    o_done,
  output logic [DW-1:0]      o_rdata,
  output logic               o_slverr,
  output logic               o_start,
  output logic [AW-1:0]      o_addr,
  output logic [DW-1:0]      o_wdata,
  output logic               o_write,
  input  logic               i_m_done,
  input  logic [DW-1:0]      i_m_rdata,
  input  logic               i_m_slverr
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   w_ptr_next;
  logic [IW-1:0]   w_sel;
  logic [IW-1:0]   w_k;
  logic            w_any;
  logic [NREQ-1:0] w_oh;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic            r_write;
  logic [DW-1:0]   r_rdata;
  logic            r_slverr;

  // Search starts just after the last served requester, so the order is total.
  always_comb begin
    int k;
    k     = 0;
    w_k   = '0;
    w_any = 1'b0;
    w_sel = '0;
    for (int off = 1; off <= NREQ; off++) begin
      k   = (int'(r_ptr) + off) % NREQ;
      w_k = IW'(k);
      if (!w_any && i_req[w_k]) begin
        w_any = 1'b1;
        w_sel = w_k;
      end
    end
  end

  always_comb begin
    w_ptr_next = r_idx;
`ifdef ARB_LOCK_EN
    // Parking the pointer one behind the winner makes it win again next time.
    if (i_lock[r_idx])
      w_ptr_next = (r_idx == '0) ? IW'(NREQ - 1) : r_idx - 1'b1;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_next = S_ISSUE;
      S_ISSUE: w_state_next = S_WAIT;
      S_WAIT:  if (i_m_done) w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr    <= IW'(NREQ - 1);
      r_idx    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_write  <= 1'b0;
      r_rdata  <= '0;
      r_slverr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any) begin
          r_idx   <= w_sel;
          r_addr  <= i_addr[int'(w_sel)*AW +: AW];
          r_wdata <= i_wdata[int'(w_sel)*DW +: DW];
          r_write <= i_write[w_sel];
        end
        S_WAIT: if (i_m_done) begin
          r_rdata  <= i_m_rdata;
          r_slverr <= i_m_slverr;
        end
        S_RESP:  r_ptr <= w_ptr_next;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_oh        = '0;
    w_oh[r_idx] = 1'b1;
    o_gnt       = (r_state != S_IDLE) ? w_oh : '0;
    o_done      = (r_state == S_RESP) ? w_oh : '0;
    o_start     = (r_state == S_ISSUE);
    o_addr      = r_addr;
    o_wdata     = r_wdata;
    o_write     = r_write;
    o_rdata     = r_rdata;
    o_slverr    = r_slverr;
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: directed steps plus random
// transactions against a rotation model of the arbitration rule.
module tb_apb_req_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic               i_clk = 1'b0;
  logic               i_reset;
  logic [NREQ-1:0]    i_req;
  logic [NREQ*AW-1:0] i_addr;
  logic [NREQ*DW-1:0] i_wdata;
  logic [NREQ-1:0]    i_write;
`ifdef ARB_LOCK_EN
  logic [NREQ-1:0]    i_lock;
`endif
  logic [NREQ-1:0]    o_gnt, o_done;
  logic [DW-1:0]      o_rdata;
  logic               o_slverr, o_start;
  logic [AW-1:0]      o_addr;
  logic [DW-1:0]      o_wdata;
  logic               o_write;
  logic               i_m_done;
  logic [DW-1:0]      i_m_rdata;
  logic               i_m_slverr;

  apb_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_write(i_write),
`ifdef ARB_LOCK_EN
    .i_lock(i_lock),
`endif
    .o_gnt(o_gnt), .o_done(o_done), .o_rdata(o_rdata), .o_slverr(o_slverr),
    .o_start(o_start), .o_addr(o_addr), .o_wdata(o_wdata), .o_write(o_write),
    .i_m_done(i_m_done), .i_m_rdata(i_m_rdata), .i_m_slverr(i_m_slverr)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int ptr;              // model: index of the last served requester
  logic [AW-1:0] a_addr  [NREQ];
  logic [DW-1:0] a_wdata [NREQ];
  logic          a_write [NREQ];

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] req, input int last);
    for (int off = 1; off <= NREQ; off++)
      if (req[(last + off) % NREQ]) return (last + off) % NREQ;
    return -1;
  endfunction

  // One full transaction from IDLE back to IDLE; checks every phase.
  task automatic txn(input logic [NREQ-1:0] req, input int mlat, input bit drop,
                     input bit lk, input logic [DW-1:0] rd, input logic se,
                     output int won);
    logic [NREQ-1:0] oh;
    for (int k = 0; k < NREQ; k++) begin
      i_addr[k*AW +: AW]  = a_addr[k];
      i_wdata[k*DW +: DW] = a_wdata[k];
      i_write[k]          = a_write[k];
    end
    i_req = req;
    won   = model_pick(req, ptr);
    oh    = '0;
    oh[won] = 1'b1;
`ifdef ARB_LOCK_EN
    i_lock = lk ? oh : '0;
`endif
    tick();
    chk("issue_gnt",   64'(o_gnt),   64'(oh));
    chk("issue_start", 64'(o_start), 64'd1);
    chk("issue_addr",  64'(o_addr),  64'(a_addr[won]));
    chk("issue_wdata", 64'(o_wdata), 64'(a_wdata[won]));
    chk("issue_write", 64'(o_write), 64'(a_write[won]));
    if (drop) i_req[won] = 1'b0;
    tick();
    chk("wait_start", 64'(o_start), 64'd0);
    chk("wait_gnt",   64'(o_gnt),   64'(oh));
    repeat (mlat) tick();
    i_m_done = 1'b1; i_m_rdata = rd; i_m_slverr = se;
    tick();
    i_m_done = 1'b0; i_m_rdata = $urandom; i_m_slverr = ~se;
    chk("resp_done",   64'(o_done),   64'(oh));
    chk("resp_rdata",  64'(o_rdata),  64'(rd));
    chk("resp_slverr", 64'(o_slverr), 64'(se));
    chk("resp_addr",   64'(o_addr),   64'(a_addr[won]));
    tick();
    chk("idle_done",  64'(o_done),  64'd0);
    chk("idle_gnt",   64'(o_gnt),   64'd0);
    chk("hold_rdata", 64'(o_rdata), 64'(rd));
    ptr = lk ? (won + NREQ - 1) % NREQ : won;
    $display("txn req=%b winner=%0d lat=%0d rdata=0x%08h slverr=%0d", req, won, mlat, rd, se);
  endtask

  initial begin
    int w;
    int g[5];
    logic [NREQ-1:0] seen;
    logic [NREQ-1:0] rq;
    i_reset = 1'b1; i_req = '0; i_addr = '0; i_wdata = '0; i_write = '0;
    i_m_done = 1'b0; i_m_rdata = '0; i_m_slverr = 1'b0;
`ifdef ARB_LOCK_EN
    i_lock = '0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      a_addr[k] = 32'h100 * k; a_wdata[k] = $urandom; a_write[k] = 1'b0;
    end
    ptr = NREQ - 1;
    tick(); tick();
    i_reset = 1'b0;
    chk("rst_gnt",   64'(o_gnt),   64'd0);
    chk("rst_done",  64'(o_done),  64'd0);
    chk("rst_start", 64'(o_start), 64'd0);
    chk("rst_addr",  64'(o_addr),  64'd0);
    chk("rst_rdata", 64'(o_rdata), 64'd0);

    // Single write from requester 1.
    a_addr[1] = 32'h1000; a_wdata[1] = 32'hDEADBEEF; a_write[1] = 1'b1;
    txn(4'b0010, 2, 1'b0, 1'b0, 32'h0, 1'b0, w);
    // Read from requester 2 with slave error.
    a_addr[2] = 32'h20; a_write[2] = 1'b0;
    txn(4'b0100, 0, 1'b0, 1'b0, 32'hCAFE0001, 1'b1, w);
    // Requester 3 drops its request after the grant; 0 should win next.
    txn(4'b1000, 1, 1'b1, 1'b0, $urandom, 1'b0, w);
    txn(4'b1111, 0, 1'b0, 1'b0, $urandom, 1'b0, w);
    chk("after_drop", 64'(w), 64'd0);

    // Reset in WAIT abandons the transaction silently.
    i_req = 4'b0001;
    tick(); tick();
    i_reset = 1'b1; i_req = '0;
    tick();
    i_reset = 1'b0;
    chk("wrst_gnt",    64'(o_gnt),    64'd0);
    chk("wrst_done",   64'(o_done),   64'd0);
    chk("wrst_addr",   64'(o_addr),   64'd0);
    chk("wrst_wdata",  64'(o_wdata),  64'd0);
    chk("wrst_write",  64'(o_write),  64'd0);
    chk("wrst_rdata",  64'(o_rdata),  64'd0);
    chk("wrst_slverr", 64'(o_slverr), 64'd0);
    ptr = NREQ - 1;
    i_m_done = 1'b1; i_m_rdata = 32'h55; i_m_slverr = 1'b1;
    tick();
    i_m_done = 1'b0;
    chk("late_done", 64'(o_done), 64'd0);
    tick();
    chk("late_gnt",   64'(o_gnt),   64'd0);
    chk("late_rdata", 64'(o_rdata), 64'd0);

    // All requesting continuously: 0,1,2,3,0 with no repeats in any 4.
    seen = '0;
    for (int t = 0; t < 5; t++) begin
      txn(4'b1111, $urandom_range(0, 2), 1'b0, 1'b0, $urandom, 1'($urandom), g[t]);
      if (t < 4) seen[g[t]] = 1'b1;
    end
    chk("rr_first", 64'(g[0]), 64'd0);
    chk("rr_fair",  64'(seen), 64'hF);
    chk("rr_wrap",  64'(g[4]), 64'(g[0]));

    // Master done while idle has no effect.
    i_req = '0; i_m_done = 1'b1;
    tick();
    i_m_done = 1'b0;
    chk("idle_mdone_done", 64'(o_done),  64'd0);
    chk("idle_mdone_gnt",  64'(o_gnt),   64'd0);
    chk("idle_mdone_strt", 64'(o_start), 64'd0);

    // Random traffic.
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < NREQ; k++) begin
        a_addr[k] = $urandom; a_wdata[k] = $urandom; a_write[k] = 1'($urandom);
      end
      rq = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      txn(rq, $urandom_range(0, 4), 1'($urandom), 1'b0, $urandom, 1'($urandom), w);
    end

`ifdef ARB_LOCK_EN
    txn(4'b0001, 0, 1'b0, 1'b0, $urandom, 1'b0, w);
    txn(4'b0110, 0, 1'b0, 1'b1, $urandom, 1'b0, g[0]);
    txn(4'b0110, 0, 1'b0, 1'b1, $urandom, 1'b0, g[1]);
    txn(4'b0110, 0, 1'b0, 1'b0, $urandom, 1'b0, g[2]);
    txn(4'b0110, 0, 1'b0, 1'b0, $urandom, 1'b0, g[3]);
    chk("lock_g0", 64'(g[0]), 64'd1);
    chk("lock_g2", 64'(g[2]), 64'd1);
    chk("lock_g3", 64'(g[3]), 64'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
Round-robin arbiter sharing one apb_master command port among NREQ requesters. Latches the winning requester's command, issues a single-cycle start to the APB master and waits for its done. Returns done/rdata/slverr to the winner only. Sits directly in front of apb_master; one transaction outstanding at a time.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 32, address width
DW, 32, data width

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous reset, active-high
i_req  in  NREQ  per-requester request, held until matching o_done
i_addr  in  NREQ*AW  packed addresses, requester k at [k*AW +: AW]
i_wdata  in  NREQ*DW  packed write data, same packing
i_write  in  NREQ  1 = write, 0 = read
o_gnt  out  NREQ  one-hot grant, held ISSUE..RESP
o_done  out  NREQ  one-hot, one-cycle completion pulse
o_rdata  out  DW  read data, valid with o_done
o_slverr  out  1  slave error, valid with o_done
o_start  out  1  one-cycle start to master
o_addr  out  AW  registered command address
o_wdata  out  DW  registered command write data
o_write  out  1  registered command direction
i_m_done  in  1  master completion pulse
i_m_rdata  in  DW  master read data
i_m_slverr  in  1  master slave error

Behaviour:
- Reset: state IDLE; o_gnt, o_done, o_start, o_slverr = 0; o_addr, o_wdata, o_rdata = 0; o_write = 0; rr pointer = NREQ-1, so requester 0 wins first. Reset mid-transaction abandons it silently; no o_done is issued.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: if any i_req, select the first asserted index searching from ptr+1 modulo NREQ. Latch index, addr, wdata and write into o_addr/o_wdata/o_write. Set o_gnt and go to ISSUE.
- ISSUE: o_start = 1 for exactly this cycle; go to WAIT. o_addr/o_wdata/o_write stay stable from ISSUE through RESP.
- WAIT: on i_m_done, register i_m_rdata into o_rdata and i_m_slverr into o_slverr. Go to RESP. No timeout; WAIT may last indefinitely.
- RESP: o_done[idx] = 1 for one cycle and o_rdata/o_slverr are valid. Update ptr = idx, clear o_gnt, go to IDLE.
- Latency: request sampled in IDLE at cycle 0, o_start at cycle 1, o_done one cycle after i_m_done. Minimum turnaround is 4 cycles per transaction.
- Fairness: a requester asserting continuously is served at most once per NREQ grants while others request.
- i_req drop before grant: ignored. Drop after grant: the transaction still completes and o_done still pulses.
- i_m_done outside WAIT: ignored.
- Simultaneous requests: rotation decides; ties are impossible because the search order is total.
- o_rdata and o_slverr hold their value until the next RESP. Read data on a write is don't-care but still registered.
- o_gnt and o_done are always one-hot or zero.

Optional Feature:
ARB_LOCK_EN. When defined, adds input i_lock [NREQ]. If the granted requester has i_lock asserted at RESP, ptr is not advanced past it: ptr is set to idx-1 modulo NREQ. The same requester then wins the next IDLE arbitration if it still requests, giving atomic back-to-back sequences. Lock is released once that requester deasserts i_lock at a RESP. When undefined: no i_lock port, pure round-robin.

Test Plan:
- Reset then single request: i_req=4'b0010, addr 0x1000, write 1, wdata 0xDEADBEEF -> o_gnt=0010 next cycle; o_start pulses once with o_addr=0x1000, o_wdata=0xDEADBEEF, o_write=1; i_m_done 3 cycles later -> o_done=0010 one cycle later.
- Read return: requester 2 read of 0x20, i_m_rdata=0xCAFE0001 with i_m_done, i_m_slverr=1 -> o_done=0100, o_rdata=0xCAFE0001, o_slverr=1 in the same cycle.
- All four requesting continuously -> grant order 0,1,2,3,0; no requester is granted twice in any 4 grants.
- Requester 3 drops i_req after grant -> transaction completes, o_done=1000, next grant goes to 0.
- Reset asserted in WAIT -> next cycle all outputs at reset values, no o_done; a later i_m_done is ignored.
- ARB_LOCK_EN: requesters 1 and 2 both requesting, i_lock[1]=1 for 2 transactions -> grants 1,1,1, then 2 after the lock drops.
